// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer between EX and MEM with a registered in_ready,
// synchronous flush, branch-taken decode and a saturating backpressure stall counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ex_wb,
  input  logic [2:0]        ex_m,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   mem_wb,
  output logic              mem_branch,
  output logic              mem_mem_write,
  output logic              mem_mem_read,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic              mem_zero,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_pc_src,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] target;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  entry_t           in_entry;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A squashed entry keeps its data but can never write memory or the register file.
  function automatic entry_t clear_ctrl(input entry_t e);
    entry_t r;
    r           = e;
    r.wb        = '0;
    r.branch    = 1'b0;
    r.mem_write = 1'b0;
    r.mem_read  = 1'b0;
    return r;
  endfunction

  assign in_entry = '{wb: ex_wb, branch: ex_m[2], mem_write: ex_m[1], mem_read: ex_m[0],
                      target: ex_branch_target, zero: ex_zero, alu: ex_alu_result,
                      store: ex_store_data, rd: ex_rd};

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = clear_ctrl(main_q);
      skid_d  = clear_ctrl(skid_q);
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // in_ready is precomputed from the next state so it leaves a flop, not out_ready logic.
    in_ready_d = (state_d != FULL);
    stall_d    = (out_valid && !out_ready && !flush) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign mem_wb            = out_valid ? main_q.wb : '0;
  assign mem_branch        = out_valid & main_q.branch;
  assign mem_mem_write     = out_valid & main_q.mem_write;
  assign mem_mem_read      = out_valid & main_q.mem_read;
  assign mem_pc_src        = out_valid & main_q.branch & main_q.zero;
  assign mem_branch_target = main_q.target;
  assign mem_zero          = main_q.zero;
  assign mem_alu_result    = main_q.alu;
  assign mem_store_data    = main_q.store;
  assign mem_rd            = main_q.rd;
  assign stall_cycles      = stall_q;

endmodule
